// File: rtl/mux2x1_trio_if.sv
// Bundle of data, select, enable and result signals for mux2x1_trio.
// master drives the inputs and observes the results; slave is the mux itself.
interface mux2x1_trio_if #(
  parameter int WIDTH = 1
);
  logic             en;
  logic             s;
  logic [WIDTH-1:0] i0;
  logic [WIDTH-1:0] i1;
  logic [WIDTH-1:0] y_df;
  logic [WIDTH-1:0] y_bh;
  logic [WIDTH-1:0] y_st;
  logic             mismatch;

  modport master (
    output en, s, i0, i1,
    input  y_df, y_bh, y_st, mismatch
  );

  modport slave (
    input  en, s, i0, i1,
    output y_df, y_bh, y_st, mismatch
  );
endinterface

// File: rtl/mux2x1_trio.sv
// Registered 2:1 select built three independent ways (dataflow, behavioural,
// gate-level). Each result is registered on its own output, and a sticky
// flag records any enabled edge on which the three networks disagreed.
module mux2x1_trio #(
  parameter int WIDTH = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  mux2x1_trio_if.slave  bus
);

  // Local names for the shared inputs; pure aliases, no logic.
  logic             sel;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;

  assign sel = bus.s;
  assign d0  = bus.i0;
  assign d1  = bus.i1;

  logic [WIDTH-1:0] f_df;
  logic [WIDTH-1:0] f_bh;
  logic [WIDTH-1:0] f_st;

  // Dataflow network: a single conditional assignment.
  assign f_df = sel ? d1 : d0;

  // Behavioural network: procedural if/else on the select.
  always_comb begin
    f_bh = '0;
    if (sel) begin
      f_bh = d1;
    end else begin
      f_bh = d0;
    end
  end

  // Structural network: each bit gets its own inverter, two ANDs and an OR,
  // so no gate is shared between bits or with the other two networks.
  logic [WIDTH-1:0] s_n;
  logic [WIDTH-1:0] p0;
  logic [WIDTH-1:0] p1;

  for (genvar b = 0; b < WIDTH; b++) begin : g_st_bit
    not u_inv  (s_n[b], sel);
    and u_and0 (p0[b], d0[b], s_n[b]);
    and u_and1 (p1[b], d1[b], sel);
    or  u_or   (f_st[b], p0[b], p1[b]);
  end

  logic [WIDTH-1:0] y_df_q;
  logic [WIDTH-1:0] y_bh_q;
  logic [WIDTH-1:0] y_st_q;
  logic             mismatch_q;

  // Capture all three results and accumulate the disagreement flag on enabled edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_df_q     <= '0;
      y_bh_q     <= '0;
      y_st_q     <= '0;
      mismatch_q <= 1'b0;
    end else if (bus.en) begin
      y_df_q     <= f_df;
      y_bh_q     <= f_bh;
      y_st_q     <= f_st;
      mismatch_q <= mismatch_q | (f_df != f_bh) | (f_df != f_st);
    end
  end

  assign bus.y_df     = y_df_q;
  assign bus.y_bh     = y_bh_q;
  assign bus.y_st     = y_st_q;
  assign bus.mismatch = mismatch_q;

endmodule

// File: tb/tb_mux2x1_trio.sv
// Directed bench for mux2x1_trio: one WIDTH=1 instance and one WIDTH=8
// instance share clock and reset; expected values are hand-computed.
module tb_mux2x1_trio;

  logic clk;
  logic rst_n;

  mux2x1_trio_if #(.WIDTH(1)) bus1 ();
  mux2x1_trio_if #(.WIDTH(8)) bus8 ();

  mux2x1_trio #(.WIDTH(1)) dut_w1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  mux2x1_trio #(.WIDTH(8)) dut_w8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  int n_assert = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_w1(input string tag, input logic y, input logic mm);
    chk({tag, "_df"}, 64'(bus1.y_df), 64'(y));
    chk({tag, "_bh"}, 64'(bus1.y_bh), 64'(y));
    chk({tag, "_st"}, 64'(bus1.y_st), 64'(y));
    chk({tag, "_mm"}, 64'(bus1.mismatch), 64'(mm));
  endtask

  task automatic chk_w8(input string tag, input logic [7:0] y, input logic mm);
    chk({tag, "_df"}, 64'(bus8.y_df), 64'(y));
    chk({tag, "_bh"}, 64'(bus8.y_bh), 64'(y));
    chk({tag, "_st"}, 64'(bus8.y_st), 64'(y));
    chk({tag, "_mm"}, 64'(bus8.mismatch), 64'(mm));
  endtask

  logic [7:0] tt_exp;
  logic [2:0] v;

  initial begin
    rst_n    = 1'b0;
    bus1.en  = 1'b1;
    bus1.s   = 1'b0;
    bus1.i0  = 1'b0;
    bus1.i1  = 1'b0;
    bus8.en  = 1'b1;
    bus8.s   = 1'b0;
    bus8.i0  = 8'h00;
    bus8.i1  = 8'h00;
    #1;
    chk_w1("rst_init_w1", 1'b0, 1'b0);
    chk_w8("rst_init_w8", 8'h00, 1'b0);

    // Reset held with arbitrary inputs and a running clock.
    for (int k = 0; k < 4; k++) begin
      bus1.en = 1'($urandom_range(0, 1));
      bus1.s  = 1'($urandom_range(0, 1));
      bus1.i0 = 1'($urandom_range(0, 1));
      bus1.i1 = 1'($urandom_range(0, 1));
      bus8.s  = 1'($urandom_range(0, 1));
      bus8.i0 = 8'($urandom_range(0, 255));
      bus8.i1 = 8'($urandom_range(0, 255));
      tick();
      chk_w1("rst_hold_w1", 1'b0, 1'b0);
      chk_w8("rst_hold_w8", 8'h00, 1'b0);
    end

    // Release with s=1, i1=1: nothing changes until the first enabled edge.
    bus1.en = 1'b1;
    bus1.s  = 1'b1;
    bus1.i0 = 1'b0;
    bus1.i1 = 1'b1;
    bus8.s  = 1'b0;
    bus8.i0 = 8'h00;
    bus8.i1 = 8'h00;
    rst_n   = 1'b1;
    #1;
    chk_w1("rel_pre", 1'b0, 1'b0);
    tick();
    chk_w1("rel_first", 1'b1, 1'b0);

    // Exhaustive truth table, (s,i0,i1) = 000..111.
    tt_exp = 8'b1010_1100;
    for (int k = 0; k < 8; k++) begin
      v       = 3'(k);
      bus1.s  = v[2];
      bus1.i0 = v[1];
      bus1.i1 = v[0];
      tick();
      chk_w1($sformatf("tt_%0d", k), tt_exp[k], 1'b0);
    end

    // Enable hold.
    bus1.en = 1'b1;
    bus1.s  = 1'b0;
    bus1.i0 = 1'b1;
    bus1.i1 = 1'b0;
    tick();
    chk_w1("en_cap", 1'b1, 1'b0);
    bus1.en = 1'b0;
    bus1.i0 = 1'b0;
    bus1.s  = 1'b1;
    bus1.i1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_w1($sformatf("en_hold_%0d", k), 1'b1, 1'b0);
    end
    bus1.en = 1'b1;
    tick();
    chk_w1("en_resume", 1'b0, 1'b0);

    // WIDTH=8 stream with alternating select, then a mid-cycle reset pulse.
    bus8.en = 1'b1;
    bus8.i0 = 8'h5A;
    bus8.i1 = 8'hA5;
    bus8.s  = 1'b0;
    tick();
    chk_w8("strm_0", 8'h5A, 1'b0);
    bus8.s = 1'b1;
    tick();
    chk_w8("strm_1", 8'hA5, 1'b0);
    bus8.s = 1'b0;
    tick();
    chk_w8("strm_2", 8'h5A, 1'b0);
    bus8.s = 1'b1;
    tick();
    chk_w8("strm_3", 8'hA5, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_w8("mid_rst_w8", 8'h00, 1'b0);
    chk_w1("mid_rst_w1", 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    #1;
    chk_w8("post_rel_pre", 8'h00, 1'b0);
    bus8.s = 1'b0;
    tick();
    chk_w8("post_rel_cap", 8'h5A, 1'b0);

    // Vector select, i0=FF / i1=00 with s toggling.
    bus8.i0 = 8'hFF;
    bus8.i1 = 8'h00;
    for (int k = 0; k < 4; k++) begin
      bus8.s = 1'(k % 2);
      tick();
      chk_w8($sformatf("vec_%0d", k), (k % 2 == 0) ? 8'hFF : 8'h00, 1'b0);
    end

    // Fault injection on the structural result of the WIDTH=1 instance.
    bus1.en = 1'b1;
    bus1.s  = 1'b1;
    bus1.i0 = 1'b0;
    bus1.i1 = 1'b1;
    tick();
    chk_w1("pre_fault", 1'b1, 1'b0);
    force dut_w1.f_st = 1'b0;
    tick();
    chk("flt_df", 64'(bus1.y_df), 64'h1);
    chk("flt_st", 64'(bus1.y_st), 64'h0);
    chk("flt_mm", 64'(bus1.mismatch), 64'h1);
    release dut_w1.f_st;
    for (int k = 0; k < 3; k++) begin
      v       = 3'(k * 3 + 1);
      bus1.s  = v[2];
      bus1.i0 = v[1];
      bus1.i1 = v[0];
      tick();
      chk($sformatf("mm_sticky_%0d", k), 64'(bus1.mismatch), 64'h1);
    end
    chk("w8_unaffected_mm", 64'(bus8.mismatch), 64'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_w1("mm_cleared", 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #50000;
    n_fail++;
    $display("FAIL timeout observed=running expected=finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mux2x1_trio.md
# mux2x1_trio

Registered 2:1 multiplexer that carries three independent implementations of the same select function: dataflow, behavioural and gate-level structural. All three are driven by the same inputs, and each result is presented on its own output. A sticky cross-check flag asserts if the implementations ever disagree. The block sits in the datapath wherever a registered 2-way select is needed and doubles as a self-checking equivalence vehicle for the three coding styles.

## Interface
- WIDTH, default 1: bit width of the data inputs and of each data output; legal range 1..64.
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous, active-low reset. Assertion clears all state immediately; deassertion is taken synchronously to clk.
- en  input  1  capture enable. When 1, results are registered on the rising edge; when 0, all outputs hold.
- s  input  1  select. 0 selects i0; 1 selects i1.
- i0  input  WIDTH  data input 0.
- i1  input  WIDTH  data input 1.
- y_df  output  WIDTH  registered result of the dataflow implementation (continuous conditional assignment).
- y_bh  output  WIDTH  registered result of the behavioural implementation (combinational procedural block, if/else or case on s).
- y_st  output  WIDTH  registered result of the structural implementation. Per bit: NOT on s, two 2-input ANDs, one 2-input OR; y = (i0 & ~s) | (i1 & s).
- mismatch  output  1  sticky flag. Set when the three combinational results differ in any bit on an enabled edge.

## Operation
- Combinational core: three separate WIDTH-bit networks each compute f = s ? i1 : i0.
  - The networks share no logic.
  - The structural network uses gate primitives or gate-level instances only, generated per bit.
- Register stage, on the rising edge of clk with rst_n=1 and en=1:
  - y_df, y_bh and y_st load their respective combinational results.
  - mismatch loads mismatch | (f_df != f_bh) | (f_df != f_st).
- With en=0, all four registers hold their values.
- mismatch clears only on reset. There is no software clear.
- With correct implementations, y_df == y_bh == y_st at all times and mismatch stays 0.
- Select decoding is 2-state; behaviour with s = X/Z is not specified and is not checked.
- All data bits are independent, with no carry or arithmetic; WIDTH only replicates the per-bit function.

## Timing
- Reset, while rst_n=0: y_df = y_bh = y_st = 0 and mismatch = 0, asynchronously, regardless of clk and en.
- Latency: one cycle. Inputs present at rising edge N appear on the outputs after edge N (valid in cycle N+1).
- Throughput: one new select result per cycle when en=1.
- en is sampled on the same edge as the data. An en=1 edge captures the inputs present at that edge.
- Reset mid-operation: outputs drop to 0 immediately.
  - The first capture after release is the first rising edge with rst_n=1 and en=1.
  - Nothing from before the reset is retained.
- Simultaneous changes of s and data ahead of an edge: the edge captures the settled combination.
- The outputs are glitch-free because they are registered.

## Test plan
- Exhaustive truth table, WIDTH=1, en=1. Apply (s,i0,i1) = 000, 001, 010, 011, 100, 101, 110, 111, one per cycle.
  - Required response, one cycle later: y_df/y_bh/y_st = 0, 0, 1, 1, 0, 1, 0, 1.
  - mismatch stays 0 throughout.
- Reset values: hold rst_n=0 with arbitrary inputs and toggling clk.
  - All outputs are 0.
  - Release rst_n with s=1, i1=1: outputs become 1 after the first enabled edge.
- Enable hold: capture s=0, i0=1 (output 1), then set en=0 and drive i0=0, s=1, i1=0 for 3 cycles.
  - Outputs stay 1.
  - Raise en: outputs become 0 one cycle later.
- Async reset mid-stream, WIDTH=8: stream s alternating with i0=0x5A, i1=0xA5.
  - Outputs alternate between 0x5A and 0xA5, one cycle delayed.
  - Pulse rst_n low between edges: outputs go to 0x00 before the next clk edge.
- Vector select, WIDTH=8: i0=0xFF, i1=0x00, toggle s each cycle.
  - All three outputs alternate 0xFF/0x00, identical bit-for-bit.
  - mismatch = 0.
- Mismatch detection (fault-injection build, WIDTH=1): force the structural result bit to 0 while s=1, i1=1.
  - mismatch = 1 after that edge.
  - mismatch remains 1 after the force is removed, until rst_n is asserted.
